// File: rtl/track_section_scheduler.sv
// track_section_scheduler
//   Round-robin arbiter sharing one single-track block section between
//   NUM_TRAINS requesters. Each grant runs GRANTED -> OCCUPIED -> HEADWAY,
//   and the occupancy sensor is supervised for entry timeout, overstay and
//   unauthorised occupancy. Faults latch until a maintainer clear.
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   train_request    level request per train (bit i = train i)
//   section_occupied synchronised occupancy sensor, 1 = section occupied
//   train_done       1-cycle pulse: granted train reports crossing complete
//   maint_hold       level, blocks new grants
//   fault_clear      1-cycle maintainer clear pulse
//   grant            registered one-hot grant, zero when none
//   signal_aspect    00 red, 01 yellow, 10 green
//   busy             GRANTED, OCCUPIED or HEADWAY
//   fault            FAULT state
//   timeout_count    saturating count of entry timeouts
module track_section_scheduler #(
  parameter int unsigned NUM_TRAINS    = 4,
  parameter int unsigned ENTRY_TIMEOUT = 20,
  parameter int unsigned OCC_TIMEOUT   = 100,
  parameter int unsigned HEADWAY       = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_TRAINS-1:0] train_request,
  input  logic                  section_occupied,
  input  logic                  train_done,
  input  logic                  maint_hold,
  input  logic                  fault_clear,
  output logic [NUM_TRAINS-1:0] grant,
  output logic [1:0]            signal_aspect,
  output logic                  busy,
  output logic                  fault,
  output logic [7:0]            timeout_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANTED,
    S_OCCUPIED,
    S_HEADWAY,
    S_FAULT
  } state_t;

  localparam logic [7:0] ENTRY_LAST = 8'(ENTRY_TIMEOUT - 1);
  localparam logic [7:0] OCC_LAST   = 8'(OCC_TIMEOUT - 1);
  localparam logic [7:0] HW_LAST    = 8'(HEADWAY - 1);

  state_t     state, state_next;
  logic [7:0] timer;
  logic [1:0] rr_ptr, rr_next;
  logic [1:0] gidx, gidx_next;
  logic       done_seen, done_next;
  logic [7:0] to_next;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] probe;
  logic       exit_cond;

  // First requester at or after rr_ptr, wrapping modulo NUM_TRAINS.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr;
    probe      = rr_ptr;
    for (int unsigned k = 0; k < NUM_TRAINS; k++) begin
      probe = rr_ptr + 2'(k);
      if (!pick_valid && train_request[probe]) begin
        pick_valid = 1'b1;
        pick_idx   = probe;
      end
    end
  end

  assign exit_cond = (done_seen | train_done) & ~section_occupied;

  always_comb begin
    state_next = state;
    gidx_next  = gidx;
    rr_next    = rr_ptr;
    done_next  = done_seen;
    to_next    = timeout_count;
    case (state)
      S_IDLE: begin
        if (section_occupied) begin
          state_next = S_FAULT;
        end else if (!maint_hold && pick_valid) begin
          state_next = S_GRANTED;
          gidx_next  = pick_idx;
        end
      end
      S_GRANTED: begin
        if (section_occupied) begin
          state_next = S_OCCUPIED;
          rr_next    = gidx + 2'd1;
        end else if (!train_request[gidx]) begin
          state_next = S_IDLE;
          rr_next    = gidx + 2'd1;
        end else if (timer == ENTRY_LAST) begin
          state_next = S_IDLE;
          rr_next    = gidx + 2'd1;
          if (timeout_count != 8'hFF) to_next = timeout_count + 8'd1;
        end
      end
      S_OCCUPIED: begin
        if (exit_cond) begin
          state_next = S_HEADWAY;
          done_next  = 1'b0;
        end else if (timer == OCC_LAST) begin
          // Drop any remembered done so it cannot release a later occupancy.
          state_next = S_FAULT;
          done_next  = 1'b0;
        end else if (train_done) begin
          done_next = 1'b1;
        end
      end
      S_HEADWAY: begin
        if (section_occupied) begin
          state_next = S_FAULT;
        end else if (timer == HW_LAST) begin
          state_next = S_IDLE;
        end
      end
      S_FAULT: begin
        if (fault_clear && !section_occupied) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode, so they always match
  // the registered state/gidx and never see inputs combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      rr_ptr        <= '0;
      gidx          <= '0;
      done_seen     <= 1'b0;
      timeout_count <= '0;
      grant         <= '0;
      signal_aspect <= 2'b00;
      busy          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_next;
      gidx          <= gidx_next;
      rr_ptr        <= rr_next;
      done_seen     <= done_next;
      timeout_count <= to_next;
      timer         <= (state_next != state) ? '0 : timer + 8'd1;
      grant         <= (state_next == S_GRANTED || state_next == S_OCCUPIED)
                       ? (NUM_TRAINS'(1) << gidx_next) : '0;
      signal_aspect <= (state_next == S_GRANTED) ? 2'b10 :
                       (state_next == S_HEADWAY) ? 2'b01 : 2'b00;
      busy          <= (state_next == S_GRANTED) || (state_next == S_OCCUPIED) ||
                       (state_next == S_HEADWAY);
      fault         <= (state_next == S_FAULT);
    end
  end

endmodule

// File: tb/tb_track_section_scheduler.sv
// Self-checking bench for track_section_scheduler: randomized traffic with a
// round-robin reference model feeding a grant scoreboard, plus directed
// timing, fault and reset scenarios.
module tb_track_section_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] train_request;
  logic       section_occupied;
  logic       train_done;
  logic       maint_hold;
  logic       fault_clear;
  logic [3:0] grant;
  logic [1:0] signal_aspect;
  logic       busy;
  logic       fault;
  logic [7:0] timeout_count;

  always #5 clk = ~clk;

  track_section_scheduler #(
    .NUM_TRAINS(4), .ENTRY_TIMEOUT(20), .OCC_TIMEOUT(100), .HEADWAY(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .train_request(train_request),
    .section_occupied(section_occupied), .train_done(train_done),
    .maint_hold(maint_hold), .fault_clear(fault_clear), .grant(grant),
    .signal_aspect(signal_aspect), .busy(busy), .fault(fault),
    .timeout_count(timeout_count)
  );

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  int model_ptr = 0;   // where the next round-robin search starts
  int model_to  = 0;   // entry timeouts seen so far (unsaturated)

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: scan trains from model_ptr upward, wrapping.
  function automatic int rr_pick(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      int t;
      t = (model_ptr + i) % 4;
      if (mask[t]) return t;
    end
    return -1;
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each new grant.
  logic [3:0] prev_grant = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_grant = '0;
    end else begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("aspect_legal", 32'(signal_aspect == 2'b11), 32'd0);
      if (prev_grant == 4'd0 && grant != 4'd0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: got %b expected none", grant);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("grant_rr", 32'(grant), 32'(e));
          check("grant_aspect", 32'(signal_aspect), 32'd2);
          check("grant_busy", 32'(busy), 32'd1);
        end
      end
      prev_grant = grant;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request mask from IDLE and wait for the resulting grant.
  task automatic issue(input logic [3:0] mask);
    int idx;
    int lat;
    maint_hold    = 1'b0;
    train_request = mask;
    idx = rr_pick(mask);
    exp_q.push_back(4'b0001 << idx);
    model_ptr = (idx + 1) % 4;
    lat = 0;
    while (grant == 4'd0 && lat < 10) begin
      step();
      lat++;
    end
    check("grant_latency", 32'(lat), 32'd1);
  endtask

  // Full crossing from a fresh grant; ends at the first IDLE cycle after headway.
  task automatic crossing(input bit done_with_exit);
    repeat ($urandom_range(0, 5)) step();
    section_occupied = 1'b1;
    step();
    check("occ_aspect_grant", 32'({signal_aspect, grant != 4'd0}), 32'({2'b00, 1'b1}));
    repeat ($urandom_range(0, 6)) step();
    if (!done_with_exit) begin
      train_done = 1'b1;
      step();
      train_done = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      section_occupied = 1'b0;
    end else begin
      train_done       = 1'b1;
      section_occupied = 1'b0;
    end
    step();
    train_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("headway_outputs", 32'({signal_aspect, grant, busy}), 32'({2'b01, 4'b0000, 1'b1}));
      step();
    end
    check("after_headway_idle", 32'({signal_aspect, grant, busy}), 32'd0);
  endtask

  // Granted train never enters; grant must last exactly ENTRY_TIMEOUT cycles.
  task automatic timeout_run();
    int held;
    held = 1;
    while (grant != 4'd0 && held < 300) begin
      step();
      if (grant != 4'd0) held++;
    end
    model_to++;
    check("entry_timeout_len", 32'(held), 32'd20);
    check("timeout_count", 32'(timeout_count), 32'(model_to > 255 ? 255 : model_to));
  endtask

  task automatic withdraw();
    train_request = '0;
    step();
    check("withdraw_idle", 32'({signal_aspect, grant, busy}), 32'd0);
  endtask

  task automatic clear_fault();
    section_occupied = 1'b0;
    fault_clear      = 1'b1;
    step();
    fault_clear = 1'b0;
    check("fault_cleared", 32'({fault, signal_aspect}), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    reset_n          = 1'b0;
    train_request    = '0;
    section_occupied = 1'b0;
    train_done       = 1'b0;
    maint_hold       = 1'b0;
    fault_clear      = 1'b0;
    #1;
    check("reset_state", 32'({grant, signal_aspect, busy, fault, timeout_count}), 32'd0);
    step();
    step();
    reset_n = 1'b1;

    // Directed round-robin on 0101: train 0, then train 2.
    issue(4'b0101);
    crossing(1'b0);
    issue(4'b0101);
    crossing(1'b1);

    // maint_hold blocks new grants.
    maint_hold    = 1'b1;
    train_request = 4'($urandom_range(1, 15));
    repeat (10) begin
      step();
      check("maint_hold_no_grant", 32'(grant), 32'd0);
    end
    issue(train_request);
    withdraw();

    // Unauthorised occupancy in IDLE.
    train_request    = '0;
    section_occupied = 1'b1;
    step();
    check("idle_occ_fault", 32'({fault, signal_aspect}), 32'({1'b1, 2'b00}));
    clear_fault();

    // Asynchronous reset in the middle of OCCUPIED.
    issue(4'b0010);
    section_occupied = 1'b1;
    step();
    step();
    #2 reset_n = 1'b0;
    #1 check("async_reset", 32'({grant, signal_aspect, busy, fault, timeout_count}), 32'd0);
    step();
    section_occupied = 1'b0;
    train_request    = '0;
    model_ptr        = 0;
    model_to         = 0;
    reset_n          = 1'b1;

    // All four requesting: 0001, 0010, 0100, 1000, 0001.
    for (int n = 0; n < 5; n++) begin
      issue(4'b1111);
      crossing(n[0]);
    end

    // Occupancy during headway is a fault.
    issue(4'b1000);
    section_occupied = 1'b1;
    step();
    train_done       = 1'b1;
    section_occupied = 1'b0;
    step();
    train_done       = 1'b0;
    train_request    = '0;
    section_occupied = 1'b1;
    step();
    check("headway_occ_fault", 32'({fault, grant}), 32'({1'b1, 4'b0000}));
    clear_fault();

    // Randomized mix of crossings, withdrawals and entry timeouts.
    for (int n = 0; n < 40; n++) begin
      int act;
      issue(4'($urandom_range(1, 15)));
      act = $urandom_range(0, 2);
      if (act == 0)      crossing(1'($urandom_range(0, 1)));
      else if (act == 1) withdraw();
      else               timeout_run();
    end
    train_request = '0;
    step();

    // Overstay: OCCUPIED must last exactly OCC_TIMEOUT cycles, then FAULT.
    begin
      int occ_cycles;
      issue(4'b0100);
      section_occupied = 1'b1;
      train_request    = '0;
      step();
      occ_cycles = 0;
      while (grant != 4'd0 && occ_cycles < 200) begin
        occ_cycles++;
        step();
      end
      check("overstay_len", 32'(occ_cycles), 32'd100);
      check("overstay_fault", 32'({fault, signal_aspect, busy}), 32'({1'b1, 2'b00, 1'b0}));
      fault_clear = 1'b1;
      step();
      fault_clear = 1'b0;
      step();
      check("clear_while_occ", 32'(fault), 32'd1);
      section_occupied = 1'b0;
      step();
      check("fault_holds_no_clear", 32'(fault), 32'd1);
      clear_fault();
    end

    // Entry timeouts until the counter saturates.
    for (int n = 0; n < 300; n++) begin
      issue(4'($urandom_range(1, 15)));
      timeout_run();
    end
    check("timeout_saturated", 32'(timeout_count), 32'd255);
    train_request = '0;
    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
